// File: rtl/noc_local_endpoint.sv
// Local-port network interface for one flattened-butterfly node: TX packing FIFO with on/off launch, RX FWFT FIFO with off generation.
// Optional statistics counters are built only when NOC_ENDPOINT_STATS_EN is defined; otherwise stat_* read as zero.
module noc_local_endpoint #(
  parameter int DATA_W       = 8,
  parameter int NODE_PER_ROW = 4,
  parameter int NODE_PER_COL = 4,
  parameter int CURR_DIM0    = 0,
  parameter int CURR_DIM1    = 0,
  parameter int TX_DEPTH     = 4,
  parameter int RX_DEPTH     = 8,
  parameter int OFF_SLACK    = 2,
  localparam int D0_W        = $clog2(NODE_PER_ROW),
  localparam int D1_W        = $clog2(NODE_PER_COL),
  localparam int PAYLOAD_W   = DATA_W - D0_W - D1_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [D0_W-1:0]      tx_dst_dim0,
  input  logic [D1_W-1:0]      tx_dst_dim1,
  input  logic [PAYLOAD_W-1:0] tx_payload,
  output logic                 noc_valid_o,
  output logic [DATA_W-1:0]    noc_data_o,
  input  logic                 noc_off_i,
  input  logic                 noc_valid_i,
  input  logic [DATA_W-1:0]    noc_data_i,
  output logic                 noc_off_o,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic [PAYLOAD_W-1:0] rx_data,
  output logic [15:0]          stat_tx,
  output logic [15:0]          stat_rx,
  output logic [15:0]          stat_drop,
  output logic [15:0]          stat_misroute
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int TX_CW = TX_AW + 1;
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam int RX_CW = RX_AW + 1;
  localparam logic [TX_CW-1:0] TX_FULL = TX_CW'(TX_DEPTH);
  localparam logic [RX_CW-1:0] RX_FULL = RX_CW'(RX_DEPTH);
  localparam logic [RX_CW-1:0] OFF_THR = RX_CW'(RX_DEPTH - OFF_SLACK);

  // ---- TX FIFO (stage p0) ----
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_AW-1:0]  tx_wr, tx_rd;
  logic [TX_CW-1:0]  tx_cnt, tx_cnt_nxt;
  logic              tx_rdy_p0, tx_push, tx_pop;

  assign tx_push    = tx_valid && tx_rdy_p0;
  assign tx_pop     = (tx_cnt != '0) && !noc_off_i;
  assign tx_cnt_nxt = tx_cnt + TX_CW'(tx_push) - TX_CW'(tx_pop);
  assign tx_ready   = tx_rdy_p0;

  always_ff @(posedge clk) begin
    if (tx_push)
      tx_mem[tx_wr] <= {tx_dst_dim0, tx_dst_dim1, tx_payload};
  end

  // ---- launch register (stage p1) ----
  logic [DATA_W-1:0] flit_p1;
  logic              vld_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr     <= '0;
      tx_rd     <= '0;
      tx_cnt    <= '0;
      tx_rdy_p0 <= 1'b0;
      vld_p1    <= 1'b0;
      flit_p1   <= '0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + TX_AW'(1);
      if (tx_pop) begin
        tx_rd   <= tx_rd + TX_AW'(1);
        flit_p1 <= tx_mem[tx_rd];
      end
      tx_cnt    <= tx_cnt_nxt;
      tx_rdy_p0 <= (tx_cnt_nxt != TX_FULL);
      vld_p1    <= tx_pop;
    end
  end

  assign noc_valid_o = vld_p1;
  assign noc_data_o  = flit_p1;

  // ---- RX FIFO, first-word fall-through ----
  logic [DATA_W-1:0] rx_mem [RX_DEPTH];
  logic [RX_AW-1:0]  rx_wr, rx_rd;
  logic [RX_CW-1:0]  rx_cnt, rx_cnt_nxt;
  logic              rx_push, rx_pop, off_q;

  assign rx_valid   = (rx_cnt != '0);
  assign rx_pop     = rx_valid && rx_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign rx_push    = noc_valid_i && ((rx_cnt != RX_FULL) || rx_pop);
  assign rx_cnt_nxt = rx_cnt + RX_CW'(rx_push) - RX_CW'(rx_pop);
  assign rx_data    = rx_mem[rx_rd][PAYLOAD_W-1:0];
  assign noc_off_o  = off_q;

  always_ff @(posedge clk) begin
    if (rx_push)
      rx_mem[rx_wr] <= noc_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_wr  <= '0;
      rx_rd  <= '0;
      rx_cnt <= '0;
      off_q  <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + RX_AW'(1);
      if (rx_pop)  rx_rd <= rx_rd + RX_AW'(1);
      rx_cnt <= rx_cnt_nxt;
      off_q  <= (rx_cnt_nxt >= OFF_THR);
    end
  end

`ifdef NOC_ENDPOINT_STATS_EN
  localparam logic [D0_W-1:0] CUR0 = D0_W'(CURR_DIM0);
  localparam logic [D1_W-1:0] CUR1 = D1_W'(CURR_DIM1);

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic rx_drop, rx_misroute;
  logic [15:0] cnt_tx, cnt_rx, cnt_drop, cnt_mis;

  assign rx_drop     = noc_valid_i && !rx_push;
  assign rx_misroute = rx_push && (noc_data_i[DATA_W-1 -: D0_W+D1_W] != {CUR0, CUR1});

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_tx   <= '0;
      cnt_rx   <= '0;
      cnt_drop <= '0;
      cnt_mis  <= '0;
    end else begin
      if (tx_pop)      cnt_tx   <= sat_inc(cnt_tx);
      if (rx_push)     cnt_rx   <= sat_inc(cnt_rx);
      if (rx_drop)     cnt_drop <= sat_inc(cnt_drop);
      if (rx_misroute) cnt_mis  <= sat_inc(cnt_mis);
    end
  end

  assign stat_tx       = cnt_tx;
  assign stat_rx       = cnt_rx;
  assign stat_drop     = cnt_drop;
  assign stat_misroute = cnt_mis;
`else
  assign stat_tx       = 16'h0;
  assign stat_rx       = 16'h0;
  assign stat_drop     = 16'h0;
  assign stat_misroute = 16'h0;
`endif

endmodule

// File: tb/tb_noc_local_endpoint.sv
// Directed bench for noc_local_endpoint at node (0,0): TX latency/back-pressure, RX off/overflow/misroute, mid-traffic reset.
module tb_noc_local_endpoint;

`ifdef NOC_ENDPOINT_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic       clk, rst;
  logic       tx_valid, tx_ready;
  logic [1:0] tx_dst_dim0, tx_dst_dim1;
  logic [3:0] tx_payload;
  logic       noc_valid_o, noc_off_i, noc_valid_i, noc_off_o;
  logic [7:0] noc_data_o, noc_data_i;
  logic       rx_valid, rx_ready;
  logic [3:0] rx_data;
  logic [15:0] stat_tx, stat_rx, stat_drop, stat_misroute;

  int n_vec = 0;
  int n_err = 0;

  noc_local_endpoint dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_dst_dim0(tx_dst_dim0), .tx_dst_dim1(tx_dst_dim1), .tx_payload(tx_payload),
    .noc_valid_o(noc_valid_o), .noc_data_o(noc_data_o), .noc_off_i(noc_off_i),
    .noc_valid_i(noc_valid_i), .noc_data_i(noc_data_i), .noc_off_o(noc_off_o),
    .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data),
    .stat_tx(stat_tx), .stat_rx(stat_rx), .stat_drop(stat_drop), .stat_misroute(stat_misroute)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; tx_valid = 1'b0; tx_dst_dim0 = 2'd0; tx_dst_dim1 = 2'd0; tx_payload = 4'h0;
    noc_off_i = 1'b0; noc_valid_i = 1'b0; noc_data_i = 8'h00; rx_ready = 1'b0;
    tick(); tick();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_noc_valid", noc_valid_o, 0);
    chk("rst_noc_data", noc_data_o, 0);
    chk("rst_noc_off", noc_off_o, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_stats", {stat_tx, stat_rx} | {stat_drop, stat_misroute}, 0);
    rst = 1'b0;
    tick();
    chk("tx_ready_after_rst", tx_ready, 1);

    // basic TX: (2,1) payload A -> 8'h9A two cycles after accept
    tx_valid = 1'b1; tx_dst_dim0 = 2'd2; tx_dst_dim1 = 2'd1; tx_payload = 4'hA;
    tick();
    tx_valid = 1'b0;
    chk("basic_lat1_valid", noc_valid_o, 0);
    tick();
    chk("basic_valid", noc_valid_o, 1);
    chk("basic_data", noc_data_o, 8'h9A);
    tick();
    chk("basic_valid_drop", noc_valid_o, 0);
    chk("basic_data_hold", noc_data_o, 8'h9A);
    chk("basic_stat_tx", stat_tx, STATS ? 1 : 0);

    // back-pressure: fill TX FIFO with off held, one refused push
    noc_off_i = 1'b1; tx_dst_dim0 = 2'd1; tx_dst_dim1 = 2'd2;
    for (int i = 1; i <= 4; i++) begin
      tx_valid = 1'b1; tx_payload = 4'(i);
      tick();
      chk("bp_fill_valid", noc_valid_o, 0);
    end
    chk("bp_full_ready", tx_ready, 0);
    tx_payload = 4'h5;
    tick();
    tx_valid = 1'b0;
    chk("bp_refused_ready", tx_ready, 0);
    chk("bp_refused_valid", noc_valid_o, 0);
    noc_off_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("bp_drain_valid", noc_valid_o, 1);
      chk("bp_drain_data", noc_data_o, 32'h60 + i);
      if (i == 1) chk("bp_ready_after_pop", tx_ready, 1);
    end
    tick();
    chk("bp_no_fifth", noc_valid_o, 0);

    // off asserted at the first possible launch edge blocks it
    tx_valid = 1'b1; tx_payload = 4'h7;
    tick();
    tx_valid = 1'b0; noc_off_i = 1'b1;
    tick();
    chk("off_block_valid", noc_valid_o, 0);
    noc_off_i = 1'b0;
    tick();
    chk("off_release_valid", noc_valid_o, 1);
    chk("off_release_data", noc_data_o, 8'h67);
    tick();
    chk("off_release_end", noc_valid_o, 0);
    chk("stat_tx_6", stat_tx, STATS ? 6 : 0);

    // RX fill to threshold, then drain
    for (int i = 1; i <= 6; i++) begin
      noc_valid_i = 1'b1; noc_data_i = 8'(i);
      tick();
      chk("rx_off_fill", noc_off_o, (i >= 6) ? 1 : 0);
    end
    noc_valid_i = 1'b0;
    chk("rx_head_valid", rx_valid, 1);
    chk("rx_head_data", rx_data, 1);
    rx_ready = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      chk("rx_drain_data", rx_data, i);
      tick();
      if (i == 1) chk("rx_off_clear", noc_off_o, 0);
    end
    rx_ready = 1'b0;
    chk("rx_empty", rx_valid, 0);

    // overflow: 10 flits into 8 entries
    for (int i = 0; i < 10; i++) begin
      noc_valid_i = 1'b1; noc_data_i = 8'(i);
      tick();
    end
    noc_valid_i = 1'b0;
    chk("ovf_rx_valid", rx_valid, 1);
    chk("ovf_off", noc_off_o, 1);
    chk("ovf_head", rx_data, 0);
    chk("ovf_stat_drop", stat_drop, STATS ? 2 : 0);
    // full FIFO accepts when popping in the same cycle
    noc_valid_i = 1'b1; noc_data_i = 8'h0C; rx_ready = 1'b1;
    tick();
    noc_valid_i = 1'b0;
    chk("ovf_swap_drop", stat_drop, STATS ? 2 : 0);
    for (int i = 1; i <= 8; i++) begin
      chk("ovf_drain_data", rx_data, (i == 8) ? 12 : i);
      tick();
    end
    rx_ready = 1'b0;
    chk("ovf_empty", rx_valid, 0);
    chk("ovf_stat_rx", stat_rx, STATS ? 15 : 0);

    // misroute: 8'h35 carries header (0,3) at node (0,0); 8'h05 is local
    chk("mis_none_yet", stat_misroute, 0);
    noc_valid_i = 1'b1; noc_data_i = 8'h35;
    tick();
    noc_data_i = 8'h05;
    tick();
    noc_valid_i = 1'b0;
    chk("mis_rx_data", rx_data, 4'h5);
    chk("mis_rx_valid", rx_valid, 1);
    chk("mis_stat", stat_misroute, STATS ? 1 : 0);
    rx_ready = 1'b1;
    tick();
    chk("mis_local_data", rx_data, 4'h5);
    chk("mis_stat_local", stat_misroute, STATS ? 1 : 0);
    tick();
    rx_ready = 1'b0;
    chk("mis_empty", rx_valid, 0);

    // reset mid-traffic with flits queued in both FIFOs and one in flight
    noc_off_i = 1'b1; tx_dst_dim0 = 2'd3; tx_dst_dim1 = 2'd0;
    for (int i = 0; i < 4; i++) begin
      tx_valid = (i < 2); tx_payload = 4'(i);
      noc_valid_i = 1'b1; noc_data_i = 8'(8 + i);
      tick();
    end
    tx_valid = 1'b0; noc_valid_i = 1'b0; noc_off_i = 1'b0;
    tick();
    chk("mid_inflight_valid", noc_valid_o, 1);
    chk("mid_inflight_data", noc_data_o, 8'hC0);
    rst = 1'b1;
    tick();
    chk("mid_rst_valid", noc_valid_o, 0);
    chk("mid_rst_data", noc_data_o, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    chk("mid_rst_off", noc_off_o, 0);
    chk("mid_rst_tx_ready", tx_ready, 0);
    chk("mid_rst_stats", {stat_tx, stat_rx} | {stat_drop, stat_misroute}, 0);
    rst = 1'b0;
    tick();
    chk("mid_post_ready", tx_ready, 1);
    chk("mid_post_valid", noc_valid_o, 0);
    tick();
    chk("mid_post_valid2", noc_valid_o, 0);
    chk("mid_post_rx_valid", rx_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
